// File: rtl/ab_match_monitor.sv
// Compares two bits on each enabled clock. Keeps saturating pass/fail counters
// and runs a mismatch-run FSM that raises a sticky alarm after FAIL_LIMIT consecutive mismatches.
module ab_match_monitor #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned FAIL_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             a,
   input  logic             b,
   input  logic             clr,
   input  logic             alarm_ack,
   output logic             match,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [7:0]       run_len,
   output logic             alarm,
   output logic [1:0]       state
);

   localparam int unsigned    RUN_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
   localparam logic [RUN_W-1:0] LIMIT   = RUN_W'(FAIL_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_MATCH = 2'd1,
      S_MISM  = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   state_t           state_q;
   logic             match_q;
   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [RUN_W-1:0] run_q;
   logic             alarm_q;
   logic             eq_c;

   assign eq_c = (a == b);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         match_q <= 1'b0;
         pass_q  <= '0;
         fail_q  <= '0;
         run_q   <= '0;
         alarm_q <= 1'b0;
      end else if (clr) begin
         state_q <= S_IDLE;
         match_q <= 1'b0;
         pass_q  <= '0;
         fail_q  <= '0;
         run_q   <= '0;
         alarm_q <= 1'b0;
      end else begin
         // Counters and match track every accepted sample, even one coinciding with an ack.
         if (en) begin
            match_q <= eq_c;
            if (eq_c) begin
               if (pass_q != CNT_MAX) pass_q <= pass_q + CNT_W'(1);
            end else begin
               if (fail_q != CNT_MAX) fail_q <= fail_q + CNT_W'(1);
            end
         end

         if (state_q == S_ALARM && alarm_ack) begin
            state_q <= S_IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
         end else if (en) begin
            unique case (state_q)
               S_IDLE, S_MATCH: begin
                  if (eq_c) begin
                     state_q <= S_MATCH;
                     run_q   <= '0;
                  end else begin
                     run_q <= RUN_W'(1);
                     if (LIMIT == RUN_W'(1)) begin
                        state_q <= S_ALARM;
                        alarm_q <= 1'b1;
                     end else begin
                        state_q <= S_MISM;
                     end
                  end
               end
               S_MISM: begin
                  if (eq_c) begin
                     state_q <= S_MATCH;
                     run_q   <= '0;
                  end else begin
                     run_q <= run_q + RUN_W'(1);
                     if (run_q + RUN_W'(1) == LIMIT) begin
                        state_q <= S_ALARM;
                        alarm_q <= 1'b1;
                     end
                  end
               end
               S_ALARM: begin
                  if (eq_c)                 run_q <= '0;
                  else if (run_q != RUN_MAX) run_q <= run_q + RUN_W'(1);
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign match    = match_q;
   assign pass_cnt = pass_q;
   assign fail_cnt = fail_q;
   assign run_len  = run_q;
   assign alarm    = alarm_q;
   assign state    = state_q;

endmodule

// File: tb/tb_ab_match_monitor.sv
// Scoreboard bench for ab_match_monitor (CNT_W=4, FAIL_LIMIT=3): directed vectors push
// hand-computed expectations, a monitor pops and compares one cycle after each issued sample.
module tb_ab_match_monitor;

   localparam int unsigned CW = 4;

   typedef struct packed {
      logic          m;
      logic [CW-1:0] p;
      logic [CW-1:0] f;
      logic [7:0]    r;
      logic          al;
      logic [1:0]    st;
   } exp_t;

   typedef struct {
      exp_t  v;
      string nm;
   } item_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, a = 1'b0, b = 1'b0, clr = 1'b0, alarm_ack = 1'b0;
   logic          match, alarm;
   logic [CW-1:0] pass_cnt, fail_cnt;
   logic [7:0]    run_len;
   logic [1:0]    state;

   item_t sb[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   ab_match_monitor #(.CNT_W(CW), .FAIL_LIMIT(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .clr(clr),
      .alarm_ack(alarm_ack), .match(match), .pass_cnt(pass_cnt),
      .fail_cnt(fail_cnt), .run_len(run_len), .alarm(alarm), .state(state)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(logic m, int p, int f, int r, logic al, int st);
      exp_t x;
      x.m  = m;
      x.p  = CW'(p);
      x.f  = CW'(f);
      x.r  = 8'(r);
      x.al = al;
      x.st = 2'(st);
      return x;
   endfunction

   function automatic void chk(string nm, exp_t exp);
      exp_t act;
      act = {match, pass_cnt, fail_cnt, run_len, alarm, state};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got m=%0b p=%0d f=%0d r=%0d al=%0b st=%0d, want m=%0b p=%0d f=%0d r=%0d al=%0b st=%0d",
                  nm, act.m, act.p, act.f, act.r, act.al, act.st,
                  exp.m, exp.p, exp.f, exp.r, exp.al, exp.st);
      end
   endfunction

   // Drive one cycle of inputs on the falling edge and queue what the next rising edge must yield.
   task automatic step(string nm, logic e, logic aa, logic bb, logic c, logic k, exp_t x);
      item_t it;
      @(negedge clk);
      en = e; a = aa; b = bb; clr = c; alarm_ack = k;
      it.v  = x;
      it.nm = nm;
      sb.push_back(it);
   endtask

   task automatic drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
      en = 1'b0; clr = 1'b0; alarm_ack = 1'b0;
   endtask

   initial begin : monitor
      item_t it;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            it = sb.pop_front();
            chk(it.nm, it.v);
         end
      end
   end

   initial begin : stim
      #3;
      chk("reset_initial", mk(0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst_n = 1'b1;

      // Mismatch run into alarm, then a match while alarmed.
      step("s1_00",     1, 0, 0, 0, 0, mk(1, 1, 0, 0, 0, 1));
      step("s2_10",     1, 1, 0, 0, 0, mk(0, 1, 1, 1, 0, 2));
      step("s3_01",     1, 0, 1, 0, 0, mk(0, 1, 2, 2, 0, 2));
      step("s4_alarm",  1, 0, 1, 0, 0, mk(0, 1, 3, 3, 1, 3));
      step("s5_match",  1, 0, 0, 0, 0, mk(1, 2, 3, 0, 1, 3));
      step("en0_hold",  0, 1, 0, 0, 0, mk(1, 2, 3, 0, 1, 3));
      step("ack_en0",   0, 0, 0, 0, 1, mk(1, 2, 3, 0, 0, 0));
      step("ack_idle",  1, 1, 1, 0, 1, mk(1, 3, 3, 0, 0, 1));
      step("mm1",       1, 1, 0, 0, 0, mk(0, 3, 4, 1, 0, 2));
      step("mm2",       1, 1, 0, 0, 0, mk(0, 3, 5, 2, 0, 2));
      step("mm3_alarm", 1, 1, 0, 0, 0, mk(0, 3, 6, 3, 1, 3));
      step("mm4_in_al", 1, 1, 0, 0, 0, mk(0, 3, 7, 4, 1, 3));
      step("ack_mism",  1, 0, 1, 0, 1, mk(0, 3, 8, 0, 0, 0));

      // Clear wins over a coincident sample.
      step("clr_only",  0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 5; i++)
         step("pass_up", 1, 1, 1, 0, 0, mk(1, i, 0, 0, 0, 1));
      step("clr_samp",  1, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));

      // Pass counter saturation at 15.
      for (int i = 1; i <= 20; i++)
         step("pass_sat", 1, 0, 0, 0, 0, mk(1, (i > 15) ? 15 : i, 0, 0, 0, 1));
      step("clr2",      0, 0, 0, 1, 0, mk(0, 0, 0, 0, 0, 0));

      // Asynchronous reset in the middle of a mismatch run.
      step("r_mm1",     1, 1, 0, 0, 0, mk(0, 0, 1, 1, 0, 2));
      step("r_mm2",     1, 0, 1, 0, 0, mk(0, 0, 2, 2, 0, 2));
      drain();
      #2;
      rst_n = 1'b0;
      #1;
      chk("reset_async", mk(0, 0, 0, 0, 0, 0));
      #1;
      rst_n = 1'b1;
      step("post_rst",  1, 1, 1, 0, 0, mk(1, 1, 0, 0, 0, 1));
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin : watchdog
      #20000;
      $display("FAIL watchdog: time limit reached, want summary before it");
      $fatal(1);
   end

endmodule

// File: doc/ab_match_monitor.md
AB_MATCH_MONITOR -- requirements
Module: ab_match_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of pass_cnt and fail_cnt (legal range 2..32).
REQ-002 SHALL have parameter FAIL_LIMIT, default 3: consecutive mismatches that raise the alarm (legal range 1..255).
REQ-003 SHALL have port clk  input  1  sampling clock; all state changes occur on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  sample enable; a and b are evaluated only on edges where en=1.
REQ-006 SHALL have port a  input  1  first compared bit.
REQ-007 SHALL have port b  input  1  second compared bit.
REQ-008 SHALL have port clr  input  1  synchronous clear of counters, run length, alarm and FSM.
REQ-009 SHALL have port alarm_ack  input  1  synchronous alarm acknowledge.
REQ-010 SHALL have port match  output  1  registered result of the last accepted sample (1 = a equals b).
REQ-011 SHALL have port pass_cnt  output  CNT_W  count of accepted samples with a equal to b.
REQ-012 SHALL have port fail_cnt  output  CNT_W  count of accepted samples with a not equal to b.
REQ-013 SHALL have port run_len  output  8  current consecutive-mismatch run length.
REQ-014 SHALL have port alarm  output  1  sticky alarm, high exactly when state is ALARM.
REQ-015 SHALL have port state  output  2  FSM state: IDLE=0, MATCH=1, MISM=2, ALARM=3.

Function
REQ-016 SHALL treat a sample as accepted on a posedge clk where en=1, clr=0 and rst_n=1.
REQ-017 SHALL update match, counters, run_len, state and alarm on the accepting edge, visible one cycle after the sample (latency 1); with en=0 all outputs hold.
REQ-018 SHALL increment pass_cnt on an accepted sample with a equal to b, else fail_cnt; each counter saturates at 2^CNT_W-1 and never wraps.
REQ-019 SHALL transition from IDLE to MATCH on an accepted match, or to MISM with run_len=1 on an accepted mismatch (directly to ALARM when FAIL_LIMIT=1).
REQ-020 SHALL in MATCH stay on match and go to MISM with run_len=1 on mismatch.
REQ-021 SHALL in MISM increment run_len on mismatch and enter ALARM when the new run_len equals FAIL_LIMIT; on match go to MATCH with run_len=0.
REQ-022 SHALL in ALARM keep counting pass/fail and updating match; run_len increments on mismatch and saturates at 255, resets to 0 on match; state stays ALARM.
REQ-023 SHALL leave ALARM only via alarm_ack=1 or clr=1, going to IDLE with run_len=0 and alarm=0; alarm_ack outside ALARM has no effect.
REQ-024 SHALL, when alarm_ack and an accepted sample coincide in ALARM, count the sample in pass_cnt/fail_cnt and update match, but move to IDLE with run_len=0 (the sample does not drive the FSM).
REQ-025 SHALL give clr priority over en and alarm_ack: on clr, all outputs return to their reset values and the coincident sample is discarded.

Reset
REQ-026 SHALL, while rst_n=0, force match=0, pass_cnt=0, fail_cnt=0, run_len=0, alarm=0, state=IDLE immediately, regardless of clk.
REQ-027 SHALL accept the first sample on the first posedge clk where rst_n=1 and en=1; reset asserted mid-run discards all history.

Verification
REQ-028 SHALL be verified with: FAIL_LIMIT=3, en=1, samples (a,b) = (0,0),(1,0),(0,1),(0,1),(0,0) -> after sample 4: fail_cnt=3, run_len=3, alarm=1, state=3; after sample 5: pass_cnt=2, match=1, run_len=0, alarm still 1.
REQ-029 SHALL be verified with: the alarm state above, then alarm_ack=1 with en=0 -> next cycle state=0, alarm=0, run_len=0, pass_cnt=2, fail_cnt=3 unchanged.
REQ-030 SHALL be verified with: alarm_ack=1 together with an accepted mismatch in ALARM -> fail_cnt+1, match=0, state=IDLE, run_len=0.
REQ-031 SHALL be verified with: CNT_W=4 and 20 accepted matches -> pass_cnt=15 held, fail_cnt=0, state=MATCH.
REQ-032 SHALL be verified with: clr=1 together with an accepted mismatch after pass_cnt=5 -> all outputs 0, state=IDLE, sample not counted.
REQ-033 SHALL be verified with: rst_n pulled low between clock edges during MISM with run_len=2 -> all outputs 0 at once; after release, (1,1) gives pass_cnt=1, state=MATCH.
